// File: rtl/sdram_pkg.sv
// Shared state codes, address layout and default timing for the 100 MHz SDRAM controller.
// The INIT_*/WORK_* codes are also decoded by the downstream command stage.
package sdram_pkg;

  typedef enum logic [3:0] {
    INIT_PWRUP = 4'h0,
    INIT_PRECH = 4'h1,
    INIT_REF1  = 4'h2,
    INIT_REF2  = 4'h3,
    INIT_REF3  = 4'h4,
    INIT_REF4  = 4'h5,
    INIT_REF5  = 4'h6,
    INIT_REF6  = 4'h7,
    INIT_REF7  = 4'h8,
    INIT_REF8  = 4'h9,
    INIT_LMR   = 4'hA,
    INIT_READY = 4'hB
  } init_state_e;

  typedef enum logic [3:0] {
    WORK_IDLE    = 4'h0,
    WORK_ACTIVE  = 4'h1,
    WORK_TRCD    = 4'h2,
    WORK_READ    = 4'h3,
    WORK_CL      = 4'h4,
    WORK_RDATA   = 4'h5,
    WORK_RD_TAIL = 4'h6,
    WORK_WRITE   = 4'h7,
    WORK_WR_TAIL = 4'h8,
    WORK_AREF    = 4'h9
  } work_state_e;

  // ADDR_REQ layout: {bank, row, col}
  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned BANK_HI = 21;
  localparam int unsigned BANK_LO = 20;
  localparam int unsigned ROW_HI  = 19;
  localparam int unsigned ROW_LO  = 8;
  localparam int unsigned COL_HI  = 7;
  localparam int unsigned COL_LO  = 0;

  localparam int unsigned DEF_T_POWERUP    = 20000;
  localparam int unsigned DEF_T_RP         = 2;
  localparam int unsigned DEF_T_RFC        = 7;
  localparam int unsigned DEF_T_MRD        = 2;
  localparam int unsigned DEF_T_RCD        = 2;
  localparam int unsigned DEF_CAS_LAT      = 3;
  localparam int unsigned DEF_BURST_LEN    = 8;
  localparam int unsigned DEF_T_WR         = 2;
  localparam int unsigned DEF_REF_INTERVAL = 1500;

  // Final in-state count value for a state held for 'period' cycles.
  function automatic logic [3:0] last_cnt(input int unsigned period);
    return 4'(period - 1);
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running auto-refresh interval counter with a sticky pending flag.
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic CLK_100M,
  input  logic RST_N,
  input  logic REF_EN,
  input  logic REF_CLR,
  output logic REF_PENDING
);

  localparam int unsigned CW = $clog2(REF_INTERVAL);

  logic [CW-1:0] ref_cnt;
  logic          wrap;

  assign wrap = REF_EN && (ref_cnt == CW'(REF_INTERVAL - 1));

  // A wrap coinciding with a clear must not be lost, so set wins.
  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      ref_cnt     <= '0;
      REF_PENDING <= 1'b0;
    end else begin
      if (REF_EN) ref_cnt <= wrap ? '0 : ref_cnt + CW'(1);
      if (wrap) REF_PENDING <= 1'b1;
      else if (REF_CLR) REF_PENDING <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_ctrl_fsm.sv
// Master sequencer: power-up init, request/refresh arbitration and data-path strobes.
// NS outputs are register D inputs; the command stage registers them onto the pins.
module sdram_ctrl_fsm
  import sdram_pkg::*;
#(
  parameter int unsigned T_POWERUP    = DEF_T_POWERUP,
  parameter int unsigned T_RP         = DEF_T_RP,
  parameter int unsigned T_RFC        = DEF_T_RFC,
  parameter int unsigned T_MRD        = DEF_T_MRD,
  parameter int unsigned T_RCD        = DEF_T_RCD,
  parameter int unsigned CAS_LAT      = DEF_CAS_LAT,
  parameter int unsigned BURST_LEN    = DEF_BURST_LEN,
  parameter int unsigned T_WR         = DEF_T_WR,
  parameter int unsigned REF_INTERVAL = DEF_REF_INTERVAL
) (
  input  logic        CLK_100M,
  input  logic        RST_N,
  input  logic        RD_REQ,
  input  logic        WR_REQ,
  input  logic [21:0] ADDR_REQ,
  output logic [21:0] SDRAM_ADDR_IN,
  output logic [3:0]  INIT_NS,
  output logic [3:0]  WORK_NS,
  output logic [3:0]  TIME_CNT_N,
  output logic        INIT_DONE,
  output logic        RD_ACK,
  output logic        WR_ACK,
  output logic        RD_DATA_VALID,
  output logic        WR_DATA_REQ,
  output logic        DQ_OE,
  output logic        BUSY
);

  init_state_e init_cs, init_ns;
  work_state_e work_cs, work_ns;
  logic [3:0]  time_cnt, time_cnt_nx;
  logic [14:0] pwr_cnt, pwr_cnt_nx;
  logic        wr_dir;
  logic        accept_rd, accept_wr, ref_take, ref_pending;

  always_comb begin
    init_ns    = init_cs;
    pwr_cnt_nx = pwr_cnt;
    case (init_cs)
      INIT_PWRUP: begin
        if (pwr_cnt == 15'(T_POWERUP - 1)) begin
          init_ns    = INIT_PRECH;
          pwr_cnt_nx = '0;
        end else begin
          pwr_cnt_nx = pwr_cnt + 15'd1;
        end
      end
      INIT_PRECH: if (time_cnt == last_cnt(T_RP)) init_ns = INIT_REF1;
      INIT_REF1, INIT_REF2, INIT_REF3, INIT_REF4, INIT_REF5, INIT_REF6, INIT_REF7:
        if (time_cnt == last_cnt(T_RFC)) init_ns = init_state_e'(init_cs + 4'd1);
      INIT_REF8:  if (time_cnt == last_cnt(T_RFC)) init_ns = INIT_LMR;
      INIT_LMR:   if (time_cnt == last_cnt(T_MRD)) init_ns = INIT_READY;
      default: ;
    endcase
  end

  always_comb begin
    work_ns   = work_cs;
    accept_rd = 1'b0;
    accept_wr = 1'b0;
    ref_take  = 1'b0;
    if (init_cs != INIT_READY) begin
      work_ns = WORK_IDLE;
    end else begin
      case (work_cs)
        WORK_IDLE: begin
          if (ref_pending) begin
            work_ns  = WORK_AREF;
            ref_take = 1'b1;
          end else if (WR_REQ) begin
            work_ns   = WORK_ACTIVE;
            accept_wr = 1'b1;
          end else if (RD_REQ) begin
            work_ns   = WORK_ACTIVE;
            accept_rd = 1'b1;
          end
        end
        WORK_ACTIVE:  work_ns = WORK_TRCD;
        WORK_TRCD:    if (time_cnt == last_cnt(T_RCD - 1))
                        work_ns = wr_dir ? WORK_WRITE : WORK_READ;
        WORK_READ:    work_ns = WORK_CL;
        WORK_CL:      if (time_cnt == last_cnt(CAS_LAT - 1)) work_ns = WORK_RDATA;
        WORK_RDATA:   if (time_cnt == last_cnt(BURST_LEN)) work_ns = WORK_RD_TAIL;
        WORK_RD_TAIL: if (time_cnt == last_cnt(T_RP)) work_ns = WORK_IDLE;
        WORK_WRITE:   if (time_cnt == last_cnt(BURST_LEN)) work_ns = WORK_WR_TAIL;
        WORK_WR_TAIL: if (time_cnt == last_cnt(T_WR + T_RP)) work_ns = WORK_IDLE;
        WORK_AREF:    if (time_cnt == last_cnt(T_RFC)) work_ns = WORK_IDLE;
        default:      work_ns = WORK_IDLE;
      endcase
    end
  end

  // One counter serves init until READY, then the work FSM; the power-up wait uses pwr_cnt.
  always_comb begin
    time_cnt_nx = time_cnt + 4'd1;
    if (init_cs != INIT_READY) begin
      if (init_ns != init_cs || init_cs == INIT_PWRUP) time_cnt_nx = '0;
    end else if (work_ns != work_cs) begin
      time_cnt_nx = '0;
    end
  end

  always_ff @(posedge CLK_100M or negedge RST_N) begin
    if (!RST_N) begin
      init_cs       <= INIT_PWRUP;
      work_cs       <= WORK_IDLE;
      time_cnt      <= '0;
      pwr_cnt       <= '0;
      wr_dir        <= 1'b0;
      SDRAM_ADDR_IN <= '0;
    end else begin
      init_cs  <= init_ns;
      work_cs  <= work_ns;
      time_cnt <= time_cnt_nx;
      pwr_cnt  <= pwr_cnt_nx;
      if (accept_rd || accept_wr) begin
        SDRAM_ADDR_IN <= ADDR_REQ;
        wr_dir        <= accept_wr;
      end
    end
  end

  sdram_refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_ref_timer (
    .CLK_100M   (CLK_100M),
    .RST_N      (RST_N),
    .REF_EN     (INIT_DONE),
    .REF_CLR    (ref_take),
    .REF_PENDING(ref_pending)
  );

  assign INIT_NS       = RST_N ? init_ns : 4'd0;
  assign WORK_NS       = RST_N ? work_ns : 4'd0;
  assign TIME_CNT_N    = RST_N ? time_cnt_nx : 4'd0;
  assign INIT_DONE     = (init_cs == INIT_READY);
  assign RD_ACK        = accept_rd;
  assign WR_ACK        = accept_wr;
  assign RD_DATA_VALID = (work_cs == WORK_RDATA);
  assign WR_DATA_REQ   = RST_N && (work_ns == WORK_WRITE);
  assign DQ_OE         = (work_cs == WORK_WRITE);
  assign BUSY          = (work_cs != WORK_IDLE) || !INIT_DONE;

endmodule

// File: tb/tb_sdram_ctrl_fsm.sv
// Directed bench for sdram_ctrl_fsm: init sequence, read/write/refresh sequencing and reset abort.
module tb_sdram_ctrl_fsm;

  logic        CLK_100M = 1'b0;
  logic        RST_N    = 1'b1;
  logic        RD_REQ   = 1'b0;
  logic        WR_REQ   = 1'b0;
  logic [21:0] ADDR_REQ = '0;
  logic [21:0] SDRAM_ADDR_IN;
  logic [3:0]  INIT_NS, WORK_NS, TIME_CNT_N;
  logic        INIT_DONE, RD_ACK, WR_ACK, RD_DATA_VALID, WR_DATA_REQ, DQ_OE, BUSY;

  sdram_ctrl_fsm dut (
    .CLK_100M     (CLK_100M),
    .RST_N        (RST_N),
    .RD_REQ       (RD_REQ),
    .WR_REQ       (WR_REQ),
    .ADDR_REQ     (ADDR_REQ),
    .SDRAM_ADDR_IN(SDRAM_ADDR_IN),
    .INIT_NS      (INIT_NS),
    .WORK_NS      (WORK_NS),
    .TIME_CNT_N   (TIME_CNT_N),
    .INIT_DONE    (INIT_DONE),
    .RD_ACK       (RD_ACK),
    .WR_ACK       (WR_ACK),
    .RD_DATA_VALID(RD_DATA_VALID),
    .WR_DATA_REQ  (WR_DATA_REQ),
    .DQ_OE        (DQ_OE),
    .BUSY         (BUSY)
  );

  always #5 CLK_100M = ~CLK_100M;

  int unsigned cyc = 0;
  always @(posedge CLK_100M) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int unsigned done_cyc = 0;

  // Flag vector {RD_DATA_VALID, WR_DATA_REQ, DQ_OE, WR_ACK, RD_ACK}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_RDV  = 5'b10000;
  localparam logic [4:0] F_WDR  = 5'b01000;
  localparam logic [4:0] F_OE   = 5'b00100;
  localparam logic [4:0] F_WACK = 5'b00010;
  localparam logic [4:0] F_RACK = 5'b00001;

  logic [3:0] q_ns[$];
  logic [4:0] q_fl[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] ns, input int n, input logic [4:0] fl);
    repeat (n) begin
      q_ns.push_back(ns);
      q_fl.push_back(fl);
    end
  endtask

  task automatic push_read();
    add(4'h1, 1, F_RACK);
    add(4'h2, 1, F_NONE);
    add(4'h3, 1, F_NONE);
    add(4'h4, 2, F_NONE);
    add(4'h5, 1, F_NONE);
    add(4'h5, 7, F_RDV);
    add(4'h6, 1, F_RDV);
    add(4'h6, 1, F_NONE);
    add(4'h0, 1, F_NONE);
  endtask

  task automatic push_write();
    add(4'h1, 1, F_WACK);
    add(4'h2, 1, F_NONE);
    add(4'h7, 1, F_WDR);
    add(4'h7, 7, F_WDR | F_OE);
    add(4'h8, 1, F_OE);
    add(4'h8, 3, F_NONE);
    add(4'h0, 1, F_NONE);
  endtask

  // Sample index i is one cycle after index i-1; requests drop at the given indices.
  task automatic play(input string tag, input int rd_drop, input int wr_drop);
    for (int i = 0; i < q_ns.size(); i++) begin
      if (i > 0) begin
        @(posedge CLK_100M);
        #1;
      end
      if (i == rd_drop) RD_REQ = 1'b0;
      if (i == wr_drop) WR_REQ = 1'b0;
      #1;
      chk($sformatf("%s ns[%0d]", tag, i), WORK_NS, q_ns[i]);
      chk($sformatf("%s flags[%0d]", tag, i),
          {RD_DATA_VALID, WR_DATA_REQ, DQ_OE, WR_ACK, RD_ACK}, q_fl[i]);
    end
    q_ns.delete();
    q_fl.delete();
  endtask

  task automatic idle_step();
    @(posedge CLK_100M);
    #1;
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) begin
      @(posedge CLK_100M);
      #1;
    end
    chk("sched_cycle", cyc, target);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " init_ns"}, INIT_NS, 4'h0);
    chk({tag, " work_ns"}, WORK_NS, 4'h0);
    chk({tag, " time_cnt_n"}, TIME_CNT_N, 4'h0);
    chk({tag, " addr"}, SDRAM_ADDR_IN, 22'h0);
    chk({tag, " init_done"}, INIT_DONE, 1'b0);
    chk({tag, " strobes"}, {RD_DATA_VALID, WR_DATA_REQ, DQ_OE, WR_ACK, RD_ACK}, 5'b0);
    chk({tag, " busy"}, BUSY, 1'b1);
  endtask

  // Entered with RST_N low. INIT_NS leads the state register by a cycle, so the last
  // reset cycle is counted into the 20000-cycle power-up run.
  task automatic init_seq(input string tag);
    logic [3:0] prev, v;
    int         len, edges;
    logic [3:0] rv[$];
    int         rl[$];
    bit         fin;
    logic [3:0] ev;
    int         el;
    @(posedge CLK_100M);
    #1;
    prev = INIT_NS;
    len  = 1;
    @(posedge CLK_100M);
    #1;
    RST_N = 1'b1;
    #1;
    chk({tag, " release_ns"}, INIT_NS, 4'h0);
    len++;
    edges = 0;
    fin   = 1'b0;
    while (!fin && edges < 21000) begin
      @(posedge CLK_100M);
      #1;
      edges++;
      if (edges == 101) chk({tag, " tcn_pwrup"}, TIME_CNT_N, 4'h0);
      if (edges == 20004) chk({tag, " tcn_ref1"}, TIME_CNT_N, 4'h3);
      v = INIT_NS;
      if (v == prev) len++;
      else begin
        rv.push_back(prev);
        rl.push_back(len);
        prev = v;
        len  = 1;
      end
      if (INIT_DONE) fin = 1'b1;
    end
    chk({tag, " done_edge"}, edges, 20060);
    chk({tag, " runs"}, rv.size(), 11);
    for (int i = 0; i < rv.size() && i < 11; i++) begin
      ev = 4'(i);
      el = (i == 0) ? 20000 : (i == 1 || i == 10) ? 2 : 7;
      chk($sformatf("%s run%0d val", tag, i), rv[i], ev);
      chk($sformatf("%s run%0d len", tag, i), rl[i], el);
    end
    chk({tag, " busy_idle"}, BUSY, 1'b0);
    chk({tag, " work_ns_idle"}, WORK_NS, 4'h0);
    done_cyc = cyc;
  endtask

  initial begin
    #2 RST_N = 1'b0;
    #20;
    check_reset("por");
    init_seq("init1");

    RD_REQ = 1'b1; ADDR_REQ = 22'h2ABCDE;
    push_read();
    play("rd", 1, -1);
    chk("rd addr", SDRAM_ADDR_IN, 22'h2ABCDE);

    idle_step();
    WR_REQ = 1'b1; ADDR_REQ = 22'h100010;
    push_write();
    play("wr", -1, 1);
    chk("wr addr", SDRAM_ADDR_IN, 22'h100010);

    idle_step();
    RD_REQ = 1'b1; WR_REQ = 1'b1; ADDR_REQ = 22'h155555;
    push_write();
    push_read();
    play("both", 16, 1);
    chk("both addr", SDRAM_ADDR_IN, 22'h155555);

    // First wrap: pending meets a write arriving in the same IDLE cycle.
    wait_until(done_cyc + 1500);
    WR_REQ = 1'b1; ADDR_REQ = 22'h0ABC01;
    add(4'h9, 7, F_NONE);
    add(4'h0, 1, F_NONE);
    push_write();
    play("ref_wr", -1, 9);
    chk("ref_wr addr", SDRAM_ADDR_IN, 22'h0ABC01);

    // Second wrap lands mid-burst; the refresh waits for the read to drain.
    wait_until(done_cyc + 3000 - 8);
    RD_REQ = 1'b1; ADDR_REQ = 22'h3C0F0F;
    push_read();
    add(4'h9, 7, F_NONE);
    add(4'h0, 1, F_NONE);
    play("ref_rd", 1, -1);

    idle_step();
    RD_REQ = 1'b1; ADDR_REQ = 22'h3FFFFF;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK_100M);
      #1;
      RD_REQ = 1'b0;
    end
    #1;
    chk("pre_rst rdv", RD_DATA_VALID, 1'b1);
    RST_N = 1'b0;
    #1;
    check_reset("midrst");
    init_seq("init2");

    RD_REQ = 1'b1; ADDR_REQ = 22'h012345;
    push_read();
    play("rd2", 1, -1);
    chk("rd2 addr", SDRAM_ADDR_IN, 22'h012345);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
